spi_crossbar_arb: RTL

//  Parametrised, glitch-safe successor to the two-port SPI wire crossbar. Routes one of PORTS

---
 rtl/spi_crossbar_arb_pkg.sv | 17 +
 rtl/spi_crossbar_arb_mux.sv | 40 ++++
 rtl/spi_crossbar_arb.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/spi_crossbar_arb_pkg.sv
// Shared types and constants for the SPI crossbar arbiter: FSM state encoding
// and the levels driven onto the physical bus while it is parked.
package spi_crossbar_arb_pkg;

    typedef enum logic [1:0] {
        ST_CONN  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_GUARD = 2'd2
    } state_e;

    localparam logic PARK_SS   = 1'b1;
    localparam logic PARK_MOSI = 1'b0;
    localparam logic PARK_MISO = 1'b0;

    localparam int GUARD_CNT_W = 8;

endpackage

// File: rtl/spi_crossbar_arb_mux.sv
// Combinational PORTS:1 SPI mux (mosi/sck/ss) and 1:PORTS miso demux.
// When park is high the bus sits at its idle levels and no port sees miso.
module spi_crossbar_arb_mux
    import spi_crossbar_arb_pkg::*;
#(
    parameter int PORTS    = 2,
    parameter int SEL_W    = 1,
    parameter bit SCK_IDLE = 1'b0
) (
    input  logic             park,
    input  logic [SEL_W-1:0] sel,
    input  logic [PORTS-1:0] mosi_ports,
    input  logic [PORTS-1:0] sck_ports,
    input  logic [PORTS-1:0] ss_ports,
    input  logic             miso,
    output logic             mosi,
    output logic             sck,
    output logic             ss,
    output logic [PORTS-1:0] miso_ports
);

    always_comb begin
        mosi       = PARK_MOSI;
        sck        = SCK_IDLE;
        ss         = PARK_SS;
        miso_ports = {PORTS{PARK_MISO}};
        if (!park) begin
            // Compare against each legal index so an unused select code never indexes past PORTS.
            for (int i = 0; i < PORTS; i++) begin
                if (sel == SEL_W'(i)) begin
                    mosi          = mosi_ports[i];
                    sck           = sck_ports[i];
                    ss            = ss_ports[i];
                    miso_ports[i] = miso;
                end
            end
        end
    end

endmodule

// File: rtl/spi_crossbar_arb.sv
// Glitch-safe SPI crossbar: switches between same-clock masters only once the bus is idle,
// then parks the bus for GUARD_CYCLES. Optional drain timeout under SPI_CROSSBAR_TIMEOUT_EN.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_CONN  | bus follows port cur_sel; switch requests accepted
// ST_DRAIN | still on cur_sel; waiting for its ss to be high (idle)
// ST_GUARD | bus parked; counting down before connecting the pending port
module spi_crossbar_arb
    import spi_crossbar_arb_pkg::*;
#(
    parameter int PORTS          = 2,
    parameter int GUARD_CYCLES   = 4,
    parameter bit SCK_IDLE       = 1'b0,
    parameter int TIMEOUT_CYCLES = 65535,
    localparam int SEL_W         = $clog2(PORTS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [SEL_W-1:0] req_sel,
    input  logic             req_valid,
    output logic             req_ready,
    output logic [SEL_W-1:0] cur_sel,
    output logic             connected,
    output logic [PORTS-1:0] grant,
    output logic             mosi,
    output logic             sck,
    output logic             ss,
    input  logic             miso,
    input  logic [PORTS-1:0] mosi_ports,
    input  logic [PORTS-1:0] sck_ports,
    input  logic [PORTS-1:0] ss_ports,
    output logic [PORTS-1:0] miso_ports,
    output logic             timeout_err
);

    localparam logic [SEL_W:0] PORTS_LIM = (SEL_W+1)'(PORTS);

    state_e                 state_q, state_d;
    logic [SEL_W-1:0]       cur_sel_q, cur_sel_d;
    logic [SEL_W-1:0]       pend_q, pend_d;
    logic [GUARD_CNT_W-1:0] cnt_q, cnt_d;
    logic                   park;
    logic                   req_ok;
    logic                   tmo_hit;

    assign park      = (state_q == ST_GUARD);
    assign connected = !park;
    assign req_ready = (state_q == ST_CONN);
    assign cur_sel   = cur_sel_q;

    // Out-of-range and same-port requests are ignored without leaving ST_CONN.
    assign req_ok = req_valid && req_ready && ({1'b0, req_sel} < PORTS_LIM) && (req_sel != cur_sel_q);

    spi_crossbar_arb_mux #(
        .PORTS    (PORTS),
        .SEL_W    (SEL_W),
        .SCK_IDLE (SCK_IDLE)
    ) u_mux (
        .park       (park),
        .sel        (cur_sel_q),
        .mosi_ports (mosi_ports),
        .sck_ports  (sck_ports),
        .ss_ports   (ss_ports),
        .miso       (miso),
        .mosi       (mosi),
        .sck        (sck),
        .ss         (ss),
        .miso_ports (miso_ports)
    );

    always_comb begin
        grant = '0;
        for (int i = 0; i < PORTS; i++) begin
            grant[i] = connected && (cur_sel_q == SEL_W'(i));
        end
    end

    always_comb begin
        state_d   = state_q;
        cur_sel_d = cur_sel_q;
        pend_d    = pend_q;
        cnt_d     = cnt_q;
        unique case (state_q)
            ST_CONN: begin
                if (req_ok) begin
                    pend_d  = req_sel;
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // Bus is unparked here, so the muxed ss is the selected port's ss.
                if (ss || tmo_hit) begin
                    cnt_d   = GUARD_CNT_W'(GUARD_CYCLES - 1);
                    state_d = ST_GUARD;
                end
            end
            ST_GUARD: begin
                if (cnt_q == '0) begin
                    cur_sel_d = pend_q;
                    state_d   = ST_CONN;
                end else begin
                    cnt_d = cnt_q - GUARD_CNT_W'(1);
                end
            end
            default: state_d = ST_CONN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_CONN;
            cur_sel_q <= '0;
            pend_q    <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            cur_sel_q <= cur_sel_d;
            pend_q    <= pend_d;
            cnt_q     <= cnt_d;
        end
    end

`ifdef SPI_CROSSBAR_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             err_q, err_d;

    // Down-counter reloaded while connected; expires after TIMEOUT_CYCLES busy drain cycles.
    always_comb begin
        tmo_d   = tmo_q;
        err_d   = err_q;
        tmo_hit = 1'b0;
        if (state_q == ST_CONN) begin
            tmo_d = TMO_W'(TIMEOUT_CYCLES - 1);
        end else if (state_q == ST_DRAIN && !ss) begin
            if (tmo_q == '0) begin
                tmo_hit = 1'b1;
                err_d   = 1'b1;
            end else begin
                tmo_d = tmo_q - TMO_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_q <= TMO_W'(TIMEOUT_CYCLES - 1);
            err_q <= 1'b0;
        end else begin
            tmo_q <= tmo_d;
            err_q <= err_d;
        end
    end

    assign timeout_err = err_q;
`else
    assign tmo_hit     = 1'b0;
    assign timeout_err = 1'b0;
`endif

endmodule
